writeback_buffer: RTL

Write-back buffer between the 4-way cache controller and the single-port RAM. Dirty victims evicted by the controller are absorbed in a small FIFO, so a miss's RAM read is not serialized behind its write-back. Entries drain to RAM in order whenever the controller leaves the RAM port idle. A combinational lookup port forwards buffered data to a read miss whose address is still pending in the buffer.

---
 rtl/memsys_pkg.sv | 16 +
 rtl/wb_match.sv | 32 +++
 rtl/writeback_buffer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/memsys_pkg.sv
// Shared memory-subsystem types and widths.
// Used by the cache controller and the write-back buffer.
package memsys_pkg;

    localparam int MEM_ADDR_WIDTH = 16;
    localparam int MEM_DATA_WIDTH = 32;
    localparam int WB_DEPTH       = 4;
    localparam int WB_PTR_BITS    = $clog2(WB_DEPTH);

    typedef struct packed {
        logic                      valid;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// DEPTH-way address comparator over the write-back entries.
// Coalescing guarantees at most one entry matches a given key.
module wb_match
    import memsys_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic [DEPTH-1:0]      valid,
    input  logic [ADDR_WIDTH-1:0] addr [DEPTH],
    input  logic [DATA_WIDTH-1:0] data [DEPTH],
    input  logic [ADDR_WIDTH-1:0] key,
    output logic                  hit,
    output logic [DEPTH-1:0]      match,
    output logic [DATA_WIDTH-1:0] match_data
);

    always_comb begin
        match      = '0;
        match_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (addr[i] == key);
            if (match[i]) begin
                match_data = match_data | data[i];
            end
        end
    end

    assign hit = |match;

endmodule

// File: rtl/writeback_buffer.sv
// Write-back FIFO between the cache controller and the RAM port.
// Coalesces repeat victims and forwards pending data to read misses.
module writeback_buffer
    import memsys_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int DEPTH      = WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [ADDR_WIDTH-1:0]  push_addr,
    input  logic [DATA_WIDTH-1:0]  push_data,
    input  logic [ADDR_WIDTH-1:0]  lookup_addr,
    output logic                   lookup_hit,
    output logic [DATA_WIDTH-1:0]  lookup_data,
    input  logic                   ram_busy,
    output logic                   ram_we,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic [DATA_WIDTH-1:0]  ram_wdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]      valid_q;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;

    logic                  drain_fire;
    logic [DEPTH-1:0]      head_sel;
    logic [DEPTH-1:0]      coal_valid;
    logic                  coal_hit;
    logic [DEPTH-1:0]      coal_vec;
    logic [DATA_WIDTH-1:0] coal_data;
    logic [DEPTH-1:0]      look_vec;
    logic                  push_fire;
    logic                  alloc;
    logic                  unused_match;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign count      = count_q;
    assign drain_fire = !empty && !ram_busy;

    assign head_sel   = DEPTH'(1) << head_q;

    // The head leaving this cycle cannot absorb a push; it reallocates.
    assign coal_valid = valid_q & ~(drain_fire ? head_sel : '0);

    wb_match #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_coal (
        .valid      (coal_valid),
        .addr       (addr_q),
        .data       (data_q),
        .key        (push_addr),
        .hit        (coal_hit),
        .match      (coal_vec),
        .match_data (coal_data)
    );

    wb_match #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_look (
        .valid      (valid_q),
        .addr       (addr_q),
        .data       (data_q),
        .key        (lookup_addr),
        .hit        (lookup_hit),
        .match      (look_vec),
        .match_data (lookup_data)
    );

    assign unused_match = ^{coal_data, look_vec};

    assign push_ready = !full || drain_fire || coal_hit;
    assign push_fire  = push_valid && push_ready;
    assign alloc      = push_fire && !coal_hit;

    assign ram_we    = drain_fire;
    assign ram_addr  = empty ? '0 : addr_q[head_q];
    assign ram_wdata = empty ? '0 : data_q[head_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (drain_fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            // When full, tail equals head; the new entry wins over the clear.
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (alloc && !drain_fire) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!alloc && drain_fire) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_fire && coal_vec[i]) begin
                    data_q[i] <= push_data;
                end
            end
            if (alloc) begin
                addr_q[tail_q] <= push_addr;
                data_q[tail_q] <= push_data;
            end
        end
    end

endmodule
